store_align_unit: RTL and testbench

//  Parametrised store path between the execute stage and the data memory. Takes one store

---
 rtl/store_pkg.sv | 18 +
 rtl/store_lane_gen.sv | 39 +++
 rtl/store_align_unit.sv | 163 ++++++++++++++++
 tb/tb_store_align_unit.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/store_pkg.sv
// Shared store-path definitions: store type codes, FSM state codes and lane-size helper.
package store_pkg;

    localparam logic [1:0] ST_SB = 2'b00;
    localparam logic [1:0] ST_SH = 2'b01;
    localparam logic [1:0] ST_SW = 2'b10;
    localparam logic [1:0] ST_SD = 2'b11;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_BEAT0 = 2'd1;
    localparam logic [1:0] S_BEAT1 = 2'd2;

    // Number of bytes written by a store type (1, 2, 4 or 8).
    function automatic logic [3:0] lane_bytes(input logic [1:0] st);
        return 4'(1) << st;
    endfunction

endpackage

// File: rtl/store_lane_gen.sv
// Combinational lane placement: positions store bytes and enables across two memory words.
module store_lane_gen
    import store_pkg::*;
#(
    parameter int unsigned XLEN = 32,
    localparam int unsigned NB = XLEN / 8,
    localparam int unsigned OFF_W = $clog2(XLEN / 8)
) (
    input  logic [1:0]        store_type,
    input  logic [OFF_W-1:0]  off,
    input  logic [XLEN-1:0]   wdata,
    output logic [2*XLEN-1:0] wide_data,
    output logic [2*NB-1:0]   wide_be,
    output logic              needs_b1,
    output logic              illegal
);

    logic [3:0]      sz;
    logic [NB-1:0]   be_lo;
    logic [XLEN-1:0] data_lo;

    // Keep only the low sz bytes of rs2, then slide them to the byte offset.
    always_comb begin
        sz      = lane_bytes(store_type);
        be_lo   = '0;
        data_lo = '0;
        for (int b = 0; b < int'(NB); b++) begin
            if (b < int'(sz)) begin
                be_lo[b]          = 1'b1;
                data_lo[8*b +: 8] = wdata[8*b +: 8];
            end
        end
        wide_data = {{XLEN{1'b0}}, data_lo} << {off, 3'b000};
        wide_be   = {{NB{1'b0}}, be_lo} << off;
        needs_b1  = |wide_be[2*NB-1:NB];
        illegal   = (store_type == ST_SD) && (XLEN < 64);
    end

endmodule

// File: rtl/store_align_unit.sv
// Store path from execute to data memory: aligns a store into one or two word beats
// with byte enables, or traps illegal/misaligned stores.
module store_align_unit
    import store_pkg::*;
#(
    parameter int unsigned XLEN = 32,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned MISALIGN_SPLIT = 1,
    localparam int unsigned NB = XLEN / 8,
    localparam int unsigned OFF_W = $clog2(XLEN / 8)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        store_type,
    input  logic [ADDR_W-1:0] addr,
    input  logic [XLEN-1:0]   wdata,
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [XLEN-1:0]   mem_wdata,
    output logic [NB-1:0]     mem_be,
    output logic              store_done,
    output logic              store_err,
    output logic [ADDR_W-1:0] err_addr
);

    localparam logic [ADDR_W-1:0] WORD_MASK   = ~ADDR_W'(NB - 1);
    localparam logic [ADDR_W-1:0] BEAT_STRIDE = ADDR_W'(NB);

    logic [1:0]        state, state_n;
    logic              req_ready_n, mem_valid_n, store_done_n, store_err_n;
    logic [ADDR_W-1:0] mem_addr_n, err_addr_n;
    logic [XLEN-1:0]   mem_wdata_n;
    logic [NB-1:0]     mem_be_n;

    // Second-beat payload captured at accept time.
    logic [ADDR_W-1:0] hi_addr, hi_addr_n;
    logic [XLEN-1:0]   hi_data, hi_data_n;
    logic [NB-1:0]     hi_be, hi_be_n;
    logic              split, split_n;

    logic [2*XLEN-1:0] wide_data;
    logic [2*NB-1:0]   wide_be;
    logic              needs_b1, illegal, trap;
    logic [ADDR_W-1:0] base_addr;

    store_lane_gen #(.XLEN(XLEN)) u_lane_gen (
        .store_type (store_type),
        .off        (addr[OFF_W-1:0]),
        .wdata      (wdata),
        .wide_data  (wide_data),
        .wide_be    (wide_be),
        .needs_b1   (needs_b1),
        .illegal    (illegal)
    );

    assign base_addr = addr & WORD_MASK;
    assign trap      = illegal || (needs_b1 && (MISALIGN_SPLIT == 0));

    always_comb begin
        state_n      = state;
        mem_valid_n  = mem_valid;
        mem_addr_n   = mem_addr;
        mem_wdata_n  = mem_wdata;
        mem_be_n     = mem_be;
        store_done_n = 1'b0;
        store_err_n  = 1'b0;
        err_addr_n   = err_addr;
        hi_addr_n    = hi_addr;
        hi_data_n    = hi_data;
        hi_be_n      = hi_be;
        split_n      = split;

        case (state)
            S_IDLE: begin
                if (req_valid) begin
                    if (trap) begin
                        store_err_n = 1'b1;
                        err_addr_n  = addr;
                    end else begin
                        state_n     = S_BEAT0;
                        mem_valid_n = 1'b1;
                        mem_addr_n  = base_addr;
                        mem_wdata_n = wide_data[XLEN-1:0];
                        mem_be_n    = wide_be[NB-1:0];
                        hi_addr_n   = base_addr + BEAT_STRIDE;
                        hi_data_n   = wide_data[2*XLEN-1:XLEN];
                        hi_be_n     = wide_be[2*NB-1:NB];
                        split_n     = needs_b1;
                    end
                end
            end
            S_BEAT0: begin
                if (mem_ready) begin
                    if (split) begin
                        state_n     = S_BEAT1;
                        mem_addr_n  = hi_addr;
                        mem_wdata_n = hi_data;
                        mem_be_n    = hi_be;
                    end else begin
                        state_n      = S_IDLE;
                        mem_valid_n  = 1'b0;
                        mem_addr_n   = '0;
                        mem_wdata_n  = '0;
                        mem_be_n     = '0;
                        store_done_n = 1'b1;
                    end
                end
            end
            S_BEAT1: begin
                if (mem_ready) begin
                    state_n      = S_IDLE;
                    mem_valid_n  = 1'b0;
                    mem_addr_n   = '0;
                    mem_wdata_n  = '0;
                    mem_be_n     = '0;
                    store_done_n = 1'b1;
                end
            end
            default: begin
                state_n     = S_IDLE;
                mem_valid_n = 1'b0;
            end
        endcase

        req_ready_n = (state_n == S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            req_ready  <= 1'b1;
            mem_valid  <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_be     <= '0;
            store_done <= 1'b0;
            store_err  <= 1'b0;
            err_addr   <= '0;
            hi_addr    <= '0;
            hi_data    <= '0;
            hi_be      <= '0;
            split      <= 1'b0;
        end else begin
            state      <= state_n;
            req_ready  <= req_ready_n;
            mem_valid  <= mem_valid_n;
            mem_addr   <= mem_addr_n;
            mem_wdata  <= mem_wdata_n;
            mem_be     <= mem_be_n;
            store_done <= store_done_n;
            store_err  <= store_err_n;
            err_addr   <= err_addr_n;
            hi_addr    <= hi_addr_n;
            hi_data    <= hi_data_n;
            hi_be      <= hi_be_n;
            split      <= split_n;
        end
    end

endmodule

// File: tb/tb_store_align_unit.sv
// Self-checking bench: three unit configurations checked against a byte-wise store model.
module tb_store_align_unit;

    logic        clk;
    logic        rst;
    int          sel;
    logic        req_valid;
    logic        mem_ready;
    logic [1:0]  st;
    logic [31:0] addr;
    logic [63:0] wdata;

    logic        rr0, mv0, sd0, se0;
    logic [31:0] ma0, ea0;
    logic [31:0] md0;
    logic [3:0]  mb0;
    logic        rr1, mv1, sd1, se1;
    logic [31:0] ma1, ea1;
    logic [31:0] md1;
    logic [3:0]  mb1;
    logic        rr2, mv2, sd2, se2;
    logic [31:0] ma2, ea2;
    logic [63:0] md2;
    logic [7:0]  mb2;

    logic        o_req_ready, o_mem_valid, o_done, o_err;
    logic [31:0] o_mem_addr, o_err_addr;
    logic [63:0] o_mem_wdata;
    logic [7:0]  o_mem_be;

    int n_checks;
    int n_errors;

    // Expected-result model state
    logic        e_ill;
    int          e_n;
    logic [31:0] e_addr [2];
    logic [63:0] e_data [2];
    logic [7:0]  e_be   [2];

    store_align_unit #(.XLEN(32), .ADDR_W(32), .MISALIGN_SPLIT(1)) u_dut32 (
        .clk(clk), .rst(rst), .req_valid(req_valid && sel == 0), .req_ready(rr0),
        .store_type(st), .addr(addr), .wdata(wdata[31:0]), .mem_valid(mv0),
        .mem_ready(mem_ready && sel == 0), .mem_addr(ma0), .mem_wdata(md0), .mem_be(mb0),
        .store_done(sd0), .store_err(se0), .err_addr(ea0)
    );

    store_align_unit #(.XLEN(32), .ADDR_W(32), .MISALIGN_SPLIT(0)) u_dut32t (
        .clk(clk), .rst(rst), .req_valid(req_valid && sel == 1), .req_ready(rr1),
        .store_type(st), .addr(addr), .wdata(wdata[31:0]), .mem_valid(mv1),
        .mem_ready(mem_ready && sel == 1), .mem_addr(ma1), .mem_wdata(md1), .mem_be(mb1),
        .store_done(sd1), .store_err(se1), .err_addr(ea1)
    );

    store_align_unit #(.XLEN(64), .ADDR_W(32), .MISALIGN_SPLIT(1)) u_dut64 (
        .clk(clk), .rst(rst), .req_valid(req_valid && sel == 2), .req_ready(rr2),
        .store_type(st), .addr(addr), .wdata(wdata), .mem_valid(mv2),
        .mem_ready(mem_ready && sel == 2), .mem_addr(ma2), .mem_wdata(md2), .mem_be(mb2),
        .store_done(sd2), .store_err(se2), .err_addr(ea2)
    );

    always_comb begin
        o_req_ready = rr0; o_mem_valid = mv0; o_done = sd0; o_err = se0;
        o_mem_addr = ma0; o_err_addr = ea0; o_mem_wdata = {32'b0, md0}; o_mem_be = {4'b0, mb0};
        if (sel == 1) begin
            o_req_ready = rr1; o_mem_valid = mv1; o_done = sd1; o_err = se1;
            o_mem_addr = ma1; o_err_addr = ea1; o_mem_wdata = {32'b0, md1}; o_mem_be = {4'b0, mb1};
        end else if (sel == 2) begin
            o_req_ready = rr2; o_mem_valid = mv2; o_done = sd2; o_err = se2;
            o_mem_addr = ma2; o_err_addr = ea2; o_mem_wdata = md2; o_mem_be = mb2;
        end
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Walk the store byte by byte and drop each byte into its memory word and lane.
    task automatic model(input int nb, input logic [1:0] t, input logic [31:0] a, input logic [63:0] d);
        logic [31:0] first, ba;
        int lane, k;
        e_ill  = (nb == 4) && (t == 2'b11);
        e_n    = 1;
        first  = a & ~32'(nb - 1);
        e_addr[0] = first;
        e_addr[1] = first + 32'(nb);
        e_data[0] = '0; e_data[1] = '0;
        e_be[0]   = '0; e_be[1]   = '0;
        if (!e_ill) begin
            for (int i = 0; i < (1 << t); i++) begin
                ba   = a + 32'(i);
                lane = int'(ba % 32'(nb));
                k    = ((ba & ~32'(nb - 1)) == first) ? 0 : 1;
                if (k == 1) e_n = 2;
                e_data[k][8*lane +: 8] = d[8*i +: 8];
                e_be[k][lane] = 1'b1;
            end
        end
    endtask

    task automatic run_store(input int s, input logic [1:0] t, input logic [31:0] a,
                             input logic [63:0] d, input int stall_cfg);
        int  nb;
        int  stall;
        logic exp_err;
        nb = (s == 2) ? 8 : 4;
        model(nb, t, a, d);
        exp_err = e_ill || (s == 1 && e_n == 2);

        @(negedge clk);
        sel = s; st = t; addr = a; wdata = d; req_valid = 1'b1;
        #1 check("req_ready_idle", 64'(o_req_ready), 64'd1);
        @(negedge clk);
        req_valid = 1'b0;

        if (exp_err) begin
            check("store_err", 64'(o_err), 64'd1);
            check("err_addr", 64'(o_err_addr), 64'(a));
            check("err_mem_valid", 64'(o_mem_valid), 64'd0);
            check("err_req_ready", 64'(o_req_ready), 64'd1);
            @(negedge clk);
            check("err_pulse", 64'(o_err), 64'd0);
            check("err_addr_held", 64'(o_err_addr), 64'(a));
            check("err_no_beat", 64'(o_mem_valid), 64'd0);
        end else begin
            for (int k = 0; k < e_n; k++) begin
                stall = (stall_cfg < 0) ? int'($urandom_range(0, 3)) : stall_cfg;
                for (int j = 0; j <= stall; j++) begin
                    check("mem_valid", 64'(o_mem_valid), 64'd1);
                    check("mem_addr", 64'(o_mem_addr), 64'(e_addr[k]));
                    check("mem_wdata", o_mem_wdata, e_data[k]);
                    check("mem_be", 64'(o_mem_be), 64'(e_be[k]));
                    check("done_early", 64'(o_done), 64'd0);
                    mem_ready = (j == stall);
                    @(negedge clk);
                end
                mem_ready = 1'b0;
            end
            check("store_done", 64'(o_done), 64'd1);
            check("idle_mem_valid", 64'(o_mem_valid), 64'd0);
            check("idle_req_ready", 64'(o_req_ready), 64'd1);
            @(negedge clk);
            check("done_pulse", 64'(o_done), 64'd0);
        end
    endtask

    initial begin
        n_checks = 0; n_errors = 0;
        rst = 1'b1; sel = 0; req_valid = 1'b0; mem_ready = 1'b0;
        st = 2'b00; addr = '0; wdata = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        for (int s = 0; s < 3; s++) begin
            sel = s;
            #1;
            check("rst_req_ready", 64'(o_req_ready), 64'd1);
            check("rst_mem_valid", 64'(o_mem_valid), 64'd0);
            check("rst_mem_be", 64'(o_mem_be), 64'd0);
            check("rst_err_addr", 64'(o_err_addr), 64'd0);
        end

        run_store(0, 2'b00, 32'h0000_1003, 64'hAABB_CCDD, 0);
        run_store(0, 2'b10, 32'h0000_2000, 64'h1234_5678, 3);
        run_store(0, 2'b10, 32'h0000_2002, 64'h1234_5678, 0);
        run_store(1, 2'b01, 32'h0000_3003, 64'h0000_BEEF, 0);
        run_store(1, 2'b11, 32'h0000_3000, 64'h1111_2222, 0);
        run_store(0, 2'b11, 32'h0000_4004, 64'h1111_2222, 0);
        run_store(2, 2'b11, 32'h0000_0105, 64'h0102_0304_0506_0708, 1);
        run_store(0, 2'b10, 32'hFFFF_FFFE, 64'hCAFE_F00D, 0);
        run_store(2, 2'b10, 32'hFFFF_FFFD, 64'h0BAD_F00D_1234_5678, 2);

        // Reset while the second beat is stalled
        @(negedge clk);
        sel = 0; st = 2'b10; addr = 32'h0000_2002; wdata = 64'h1234_5678; req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0; mem_ready = 1'b1;
        @(negedge clk);
        mem_ready = 1'b0;
        check("b1_valid", 64'(o_mem_valid), 64'd1);
        check("b1_addr", 64'(o_mem_addr), 64'h2004);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_mid_valid", 64'(o_mem_valid), 64'd0);
        check("rst_mid_ready", 64'(o_req_ready), 64'd1);
        check("rst_mid_done", 64'(o_done), 64'd0);
        @(negedge clk);
        check("rst_mid_done2", 64'(o_done), 64'd0);

        for (int n = 0; n < 200; n++) begin
            logic [31:0] ra;
            ra = $urandom;
            if ($urandom_range(0, 7) == 0) ra = 32'hFFFF_FFF8 | 32'($urandom_range(0, 7));
            run_store(int'($urandom_range(0, 2)), 2'($urandom_range(0, 3)), ra,
                      {$urandom, $urandom}, -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
